// File: rtl/spi_ram_arbiter_if.sv
// Bundle of the SPI command/response, host port and RAM port signals of spi_ram_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface spi_ram_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic [9:0]           rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 host_req;
    logic                 host_we;
    logic [ADDR_SIZE-1:0] host_addr;
    logic [ADDR_SIZE-1:0] host_wdata;
    logic                 host_gnt;
    logic [ADDR_SIZE-1:0] host_rdata;
    logic                 host_rvalid;
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [ADDR_SIZE-1:0] ram_wdata;
    logic [ADDR_SIZE-1:0] ram_rdata;
    logic                 spi_overflow;

    modport slave (
        input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, spi_overflow
    );

    modport master (
        output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
               ram_en, ram_we, ram_addr, ram_wdata, spi_overflow
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between a buffered SPI command stream and a host port.
// SPI commands win unless the host has waited MAX_WAIT cycles; an empty buffer is bypassed.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE      = 8,
    parameter int SPI_FIFO_DEPTH = 2,
    parameter int MAX_WAIT       = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_arbiter_if.slave bus
);
    localparam int PW = $clog2(SPI_FIFO_DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [PW:0]   PTR_ONE    = (PW + 1)'(1);
    localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RD_WAIT = 2'd2} state_t;

    state_t               state_r, state_s;
    logic [9:0]           fifo_mem_r [SPI_FIFO_DEPTH];
    logic [PW:0]          wr_ptr_r, rd_ptr_r;
    logic                 fifo_empty_s, fifo_full_s, spi_avail_s, push_s, pop_s;
    logic [9:0]           head_s;
    logic [ADDR_SIZE-1:0] head_data_s;
    logic [WW-1:0]        wait_cnt_r;
    logic                 sel_host_s, sel_spi_wr_s, sel_spi_rd_s, ld_wr_addr_s, ld_rd_addr_s;
    logic [ADDR_SIZE-1:0] wr_addr_reg, rd_addr_reg;
    logic                 rd_pending_r, rd_to_spi_r;
    logic [ADDR_SIZE-1:0] tx_data_r, host_rdata_r, ram_addr_r, ram_wdata_r;
    logic                 tx_valid_r, host_gnt_r, host_rvalid_r, ram_en_r, ram_we_r, overflow_r;

    // With an empty buffer the incoming command is served directly, so it is never also stored.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign spi_avail_s  = !fifo_empty_s || bus.rx_valid;
    assign head_s       = fifo_empty_s ? bus.rx_data : fifo_mem_r[rd_ptr_r[PW-1:0]];
    assign head_data_s  = ADDR_SIZE'(head_s[7:0]);
    assign push_s       = bus.rx_valid && !(pop_s && fifo_empty_s) && (!fifo_full_s || pop_s);

    // Command buffer storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[PW-1:0]] <= bus.rx_data;
        end
    end

    // Command buffer pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s && !fifo_empty_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Host starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (host_gnt_r) begin
            wait_cnt_r <= '0;
        end else if (bus.host_req && (wait_cnt_r != WAIT_LIMIT)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Next-state and IDLE selection.
    always_comb begin
        state_s      = state_r;
        pop_s        = 1'b0;
        sel_host_s   = 1'b0;
        sel_spi_wr_s = 1'b0;
        sel_spi_rd_s = 1'b0;
        ld_wr_addr_s = 1'b0;
        ld_rd_addr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.host_req && (wait_cnt_r == WAIT_LIMIT)) begin
                    sel_host_s = 1'b1;
                    state_s    = ACCESS;
                end else if (spi_avail_s) begin
                    pop_s = 1'b1;
                    case (head_s[9:8])
                        2'b00:   ld_wr_addr_s = 1'b1;
                        2'b10:   ld_rd_addr_s = 1'b1;
                        2'b01: begin
                            sel_spi_wr_s = 1'b1;
                            state_s      = ACCESS;
                        end
                        default: begin
                            sel_spi_rd_s = 1'b1;
                            state_s      = ACCESS;
                        end
                    endcase
                end else if (bus.host_req) begin
                    sel_host_s = 1'b1;
                    state_s    = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS:  state_s = rd_pending_r ? RD_WAIT : IDLE;
            RD_WAIT: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered RAM port, strobes, read capture and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= '0;
            ram_wdata_r   <= '0;
            host_gnt_r    <= 1'b0;
            tx_valid_r    <= 1'b0;
            tx_data_r     <= '0;
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= '0;
            overflow_r    <= 1'b0;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            rd_pending_r  <= 1'b0;
            rd_to_spi_r   <= 1'b0;
        end else begin
            ram_en_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= '0;
            ram_wdata_r   <= '0;
            host_gnt_r    <= 1'b0;
            tx_valid_r    <= 1'b0;
            host_rvalid_r <= 1'b0;
            if (sel_host_s) begin
                ram_en_r     <= 1'b1;
                ram_we_r     <= bus.host_we;
                ram_addr_r   <= bus.host_addr;
                ram_wdata_r  <= bus.host_wdata;
                host_gnt_r   <= 1'b1;
                rd_pending_r <= !bus.host_we;
                rd_to_spi_r  <= 1'b0;
            end else if (sel_spi_wr_s) begin
                ram_en_r     <= 1'b1;
                ram_we_r     <= 1'b1;
                ram_addr_r   <= wr_addr_reg;
                ram_wdata_r  <= head_data_s;
                rd_pending_r <= 1'b0;
            end else if (sel_spi_rd_s) begin
                ram_en_r     <= 1'b1;
                ram_addr_r   <= rd_addr_reg;
                rd_pending_r <= 1'b1;
                rd_to_spi_r  <= 1'b1;
            end
            if (ld_wr_addr_s) wr_addr_reg <= head_data_s;
            if (ld_rd_addr_s) rd_addr_reg <= head_data_s;
            if (state_r == RD_WAIT) begin
                if (rd_to_spi_r) begin
                    tx_data_r  <= bus.ram_rdata;
                    tx_valid_r <= 1'b1;
                end else begin
                    host_rdata_r  <= bus.ram_rdata;
                    host_rvalid_r <= 1'b1;
                end
            end
            if (bus.rx_valid && fifo_full_s && !pop_s) overflow_r <= 1'b1;
        end
    end

    assign bus.ram_en       = ram_en_r;
    assign bus.ram_we       = ram_we_r;
    assign bus.ram_addr     = ram_addr_r;
    assign bus.ram_wdata    = ram_wdata_r;
    assign bus.host_gnt     = host_gnt_r;
    assign bus.host_rdata   = host_rdata_r;
    assign bus.host_rvalid  = host_rvalid_r;
    assign bus.tx_data      = tx_data_r;
    assign bus.tx_valid     = tx_valid_r;
    assign bus.spi_overflow = overflow_r;
endmodule
